// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter for the single write port of the register file.
// Define REG_WR_ARB_CLEAR_EN to clear every entry to zero after reset.
module reg_wr_arbiter #(
  parameter int addr_width_p = 6,
  parameter int num_req_p    = 4,
  parameter int data_width_p = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_yumi_o,
  output logic                              wen_o,
  output logic [addr_width_p-1:0]           wa_o,
  output logic [data_width_p-1:0]           write_data_o,
  output logic                              busy_o,
  output logic [$clog2(num_req_p)-1:0]      grant_id_o
);

  localparam int          id_w = $clog2(num_req_p);
  localparam int unsigned nr   = num_req_p;

  logic [id_w-1:0]         last_r;
  logic [id_w-1:0]         grant_idx;
  logic [id_w-1:0]         cand;
  logic                    grant_found;
  logic                    clearing;
  logic [addr_width_p-1:0] clear_wa;

`ifdef REG_WR_ARB_CLEAR_EN
  typedef enum logic {S_CLEAR, S_ARB} state_e;

  state_e                  state_r, state_n;
  logic [addr_width_p-1:0] cnt_r, cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_CLEAR;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    if (state_r == S_CLEAR) begin
      cnt_n = cnt_r + 1'b1;
      if (cnt_r == '1) state_n = S_ARB;
    end
  end

  assign clearing = (state_r == S_CLEAR);
  assign clear_wa = cnt_r;
`else
  assign clearing = 1'b0;
  assign clear_wa = '0;
`endif

  // Search starts just after the last winner and wraps modulo num_req_p.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned off = 1; off <= nr; off++) begin
      cand = id_w'((32'(last_r) + off) % nr);
      if (!grant_found && req_v_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_r <= id_w'(num_req_p - 1);
    end else if (!clearing && grant_found) begin
      last_r <= grant_idx;
    end
  end

  always_comb begin
    req_yumi_o   = '0;
    wen_o        = 1'b0;
    wa_o         = '0;
    write_data_o = '0;
    busy_o       = 1'b0;
    grant_id_o   = '0;
    if (!reset) begin
      if (clearing) begin
        wen_o  = 1'b1;
        wa_o   = clear_wa;
        busy_o = 1'b1;
      end else if (grant_found) begin
        req_yumi_o[grant_idx] = 1'b1;
        grant_id_o            = grant_idx;
        wen_o                 = 1'b1;
        wa_o                  = req_addr_i[grant_idx*addr_width_p +: addr_width_p];
        write_data_o          = req_data_i[grant_idx*data_width_p +: data_width_p];
      end
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed self-checking bench for reg_wr_arbiter with a register file model.
module tb_reg_wr_arbiter;

  localparam int AW = 6;
  localparam int NR = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_v_i;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0] req_yumi_o;
  logic          wen_o;
  logic [AW-1:0] wa_o;
  logic [DW-1:0] write_data_o;
  logic          busy_o;
  logic [1:0]    grant_id_o;

  logic [DW-1:0] mem [2**AW];

  int checks   = 0;
  int failures = 0;

  reg_wr_arbiter #(.addr_width_p(AW), .num_req_p(NR), .data_width_p(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_v_i      (req_v_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .req_yumi_o   (req_yumi_o),
    .wen_o        (wen_o),
    .wa_o         (wa_o),
    .write_data_o (write_data_o),
    .busy_o       (busy_o),
    .grant_id_o   (grant_id_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wen_o) mem[wa_o] <= write_data_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares the whole output bus in one go: {wen,busy,yumi,gid,wa,data}.
  task automatic chk_bus(input string tag, input logic e_wen, input logic e_busy,
                         input logic [NR-1:0] e_yumi, input logic [1:0] e_gid,
                         input logic [AW-1:0] e_wa, input logic [DW-1:0] e_wd);
    chk(tag, 64'({wen_o, busy_o, req_yumi_o, grant_id_o, wa_o, write_data_o}),
             64'({e_wen, e_busy, e_yumi, e_gid, e_wa, e_wd}));
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr_i[k*AW +: AW] = a;
    req_data_i[k*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'hDEAD_BEEF;
    reset      = 1'b1;
    req_v_i    = 4'b1111;
    req_addr_i = '0;
    req_data_i = '0;
    for (int k = 0; k < NR; k++) set_req(k, AW'(8 + k), 32'hD0 + k);
    step();
    step();
    sample();
    chk_bus("reset_outputs", 1'b0, 1'b0, 4'b0000, 2'd0, '0, '0);
    step();
    reset = 1'b0;

`ifdef REG_WR_ARB_CLEAR_EN
    for (int i = 0; i < 20; i++) begin
      sample();
      chk_bus($sformatf("clear_pre_%0d", i), 1'b1, 1'b1, 4'b0000, 2'd0, AW'(i), '0);
      step();
    end
    reset = 1'b1;
    sample();
    chk_bus("reset_mid_clear", 1'b0, 1'b0, 4'b0000, 2'd0, '0, '0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 2**AW; i++) begin
      sample();
      chk_bus($sformatf("clear_%0d", i), 1'b1, 1'b1, 4'b0000, 2'd0, AW'(i), '0);
      step();
    end
    begin
      int nz = 0;
      for (int i = 0; i < 2**AW; i++) if (mem[i] !== '0) nz++;
      chk("clear_all_zero", 64'(nz), 64'd0);
    end
`else
    // No clear: reset goes straight to arbitration.
    reset   = 1'b1;
    req_v_i = 4'b0100;
    step();
    reset = 1'b0;
    sample();
    chk_bus("noclr_first_grant", 1'b1, 1'b0, 4'b0100, 2'd2, AW'(10), 32'hD2);
    step();
    reset   = 1'b1;
    req_v_i = 4'b1111;
    step();
    reset = 1'b0;
`endif

    // All four valid: strict rotation starting at requester 0.
    for (int i = 0; i < 8; i++) begin
      sample();
      chk_bus($sformatf("rr_%0d", i), 1'b1, 1'b0, 4'(1 << (i % 4)), 2'(i % 4),
              AW'(8 + i % 4), 32'hD0 + (i % 4));
      step();
    end
    for (int k = 0; k < NR; k++)
      chk($sformatf("rf_req%0d", k), 64'(mem[8 + k]), 64'(32'hD0 + k));

    // Make requester 1 the last winner, then only 0 and 3 request.
    req_v_i = 4'b0010;
    sample();
    chk_bus("sparse_setup", 1'b1, 1'b0, 4'b0010, 2'd1, AW'(9), 32'hD1);
    step();
    req_v_i = 4'b1001;
    sample();
    chk_bus("sparse_a", 1'b1, 1'b0, 4'b1000, 2'd3, AW'(11), 32'hD3);
    step();
    sample();
    chk_bus("sparse_b", 1'b1, 1'b0, 4'b0001, 2'd0, AW'(8), 32'hD0);
    step();
    sample();
    chk_bus("sparse_c", 1'b1, 1'b0, 4'b1000, 2'd3, AW'(11), 32'hD3);
    step();
    req_v_i = 4'b0000;
    sample();
    chk_bus("idle", 1'b0, 1'b0, 4'b0000, 2'd0, '0, '0);
    step();

    // Same-address collision: later grant wins.
    set_req(1, AW'(5), 32'h0000_00AA);
    set_req(2, AW'(5), 32'h0000_00BB);
    req_v_i = 4'b0010;
    sample();
    chk_bus("coll_req1", 1'b1, 1'b0, 4'b0010, 2'd1, AW'(5), 32'hAA);
    step();
    req_v_i = 4'b0100;
    sample();
    chk_bus("coll_req2", 1'b1, 1'b0, 4'b0100, 2'd2, AW'(5), 32'hBB);
    step();
    req_v_i = 4'b0000;
    sample();
    chk("coll_rf_addr5", 64'(mem[5]), 64'h0000_00BB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Owns the single write port of the asynchronous-read/synchronous-write register file and shares it among num_req_p requesters (e.g. ALU writeback, load return, CSR/debug writer).
- After reset it sequences a clear of every register entry to zero, then grants one write per cycle using round-robin arbitration.
- The output write bus connects directly to the register file's wen/wa/write_data inputs.

Parameters:
- addr_width_p, 6, register address width; the file holds 2**addr_width_p entries.
- num_req_p, 4, number of write requesters; minimum 2.
- data_width_p, 32, write data width.

Ports:
- clk  input  1  clock, rising edge; the only clock.
- reset  input  1  synchronous, active-high reset.
- req_v_i  input  num_req_p  per-requester write request valid.
- req_addr_i  input  num_req_p*addr_width_p  flattened write addresses; requester k occupies slice [k*addr_width_p +: addr_width_p].
- req_data_i  input  num_req_p*data_width_p  flattened write data; requester k occupies slice [k*data_width_p +: data_width_p].
- req_yumi_o  output  num_req_p  one-hot grant; the request is consumed this cycle.
- wen_o  output  1  register file write enable.
- wa_o  output  addr_width_p  register file write address.
- write_data_o  output  data_width_p  register file write data.
- busy_o  output  1  high while the clear sequence runs.
- grant_id_o  output  $clog2(num_req_p)  index of the granted requester; 0 when there is no grant.

Behaviour:
States:
- CLEAR: cnt_r walks through every address.
- ARB: normal arbitration.

Reset (while reset=1, evaluated at a clock edge):
- state <- CLEAR (or ARB without the macro).
- cnt_r <- 0.
- last_r <- num_req_p-1, so requester 0 has highest priority on the first arbitration.
- During any cycle with reset high, all outputs are forced: wen_o=0, req_yumi_o=0, wa_o=0, write_data_o=0, grant_id_o=0, busy_o=0.
- Reset asserted mid-CLEAR restarts the clear at address 0. Reset asserted mid-ARB drops any in-flight grant; nothing is written that cycle.

CLEAR:
- Outputs: wen_o=1, wa_o=cnt_r, write_data_o=0, busy_o=1, req_yumi_o=0.
- cnt_r increments each cycle.
- When cnt_r==2**addr_width_p-1, that write happens and the next state is ARB; cnt_r wraps to 0.
- Exactly 2**addr_width_p clear writes occur.
- Requests are ignored and must be held by their senders.

ARB (combinational grant, zero latency):
- Search order: requesters (last_r+1) mod num_req_p, (last_r+2) mod num_req_p, and so on, wrapping.
- The first valid requester in that order, g, is granted:
  - req_yumi_o[g]=1, grant_id_o=g.
  - wen_o=1, wa_o=req_addr_i slice g, write_data_o=req_data_i slice g.
  - last_r <- g at the clock edge.
- With no valid requests: wen_o=0, wa_o=0, write_data_o=0, last_r unchanged.
- Exactly one write per cycle; at most one yumi bit is set.
- Handshake: req_v_i must not depend combinationally on req_yumi_o. A requester holds v/addr/data until it sees yumi; the consume happens on the same edge as the register file write.
- A single continuously valid requester is granted every cycle.
- With all requesters valid, grants rotate 0,1,2,3,0,… with one grant per cycle.
- Two requesters writing the same address in consecutive cycles: both writes occur in grant order and the later one wins. No coalescing.
- Arbitration ignores address values; a write to address 0 is treated like any other.

Optional Feature:
- Macro: REG_WR_ARB_CLEAR_EN.
- Defined: the CLEAR state and cnt_r exist. Reset enters CLEAR, and busy_o is high for 2**addr_width_p cycles after reset deasserts.
- Undefined: no CLEAR state and no cnt_r. Reset enters ARB directly, busy_o is tied 0, and register contents after reset are undefined.

Test Plan (addr_width_p=6, num_req_p=4, macro defined unless noted):
- Clear sequence: deassert reset, then req_v_i=4'b1111 held. Required response:
  - busy_o=1, wen_o=1 and wa_o=0..63 sequentially with write_data_o=0 over 64 cycles.
  - req_yumi_o=0 throughout.
  - First grant in cycle 65 goes to requester 0.
- Round-robin: after the clear, all four requesters valid for 8 cycles. Required response: grant_id_o=0,1,2,3,0,1,2,3; the register file model holds each requester's data at its address.
- Sparse requests: after last grant=1, only req 0 and req 3 are valid. Required response: grant to 3, then 0, then 3; a requester with no valid is never granted.
- Same-address collision: req1 writes 0x0000_00AA to address 5, then req2 writes 0x0000_00BB to address 5. Required response: reading address 5 returns 0x0000_00BB.
- Reset mid-clear: assert reset at cnt_r=20 for 1 cycle. Required response: outputs are 0 during reset, the clear restarts at wa_o=0, and all 64 entries end at 0.
- Macro undefined: deassert reset with req 2 valid. Required response: grant to req 2 in the first cycle after reset; busy_o is never 1.
